dcc_packet_scheduler: RTL and testbench

Feeds the DCC bit-stream engine with packets: supplies its cmd_word and advances whenever the engine's cmd_index changes, i.e. when a packet has been consumed. Arbitrates between a host one-shot queue (priority, repeated) and a table of refresh slots (round-robin). Falls back to the DCC idle packet when neither source has work. Sits between the host register bank and the engine.

---
 rtl/dcc_packet_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_dcc_packet_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcc_packet_scheduler.sv
// DCC packet scheduler: feeds the bit-stream engine from a repeated one-shot queue,
// round-robin refresh slots, or the idle packet. Optional macro: DCC_SCHED_FAIRNESS_EN.
module dcc_packet_scheduler #(
    parameter int unsigned SLOTS      = 8,
    parameter int unsigned QDEPTH     = 4,
    parameter int unsigned REPEAT     = 3,
    parameter int unsigned FAIR_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [9:0]               eng_index,
    output logic [31:0]              cmd_word,
    input  logic                     slot_wr,
    input  logic [$clog2(SLOTS)-1:0] slot_sel,
    input  logic                     slot_en,
    input  logic [29:0]              slot_data,
    input  logic                     q_wr,
    input  logic [29:0]              q_data,
    output logic                     q_full,
    output logic                     q_overflow,
    output logic [1:0]               cur_src,
    output logic [$clog2(SLOTS)-1:0] cur_slot
);

    localparam int unsigned SW = $clog2(SLOTS);
    localparam int unsigned QW = $clog2(QDEPTH);
    localparam int unsigned CW = QW + 1;
    localparam int unsigned RW = 4;
    localparam logic [31:0] IDLE_WORD = 32'h0D0000FF;
    localparam logic [1:0]  SRC_IDLE  = 2'b00;
    localparam logic [1:0]  SRC_QUEUE = 2'b01;
    localparam logic [1:0]  SRC_REFR  = 2'b10;

    // Parameter sanity check at elaboration
    generate
        if (REPEAT < 1 || REPEAT > 15 || FAIR_LIMIT < 1 || QDEPTH < 2 || SLOTS < 2) begin : g_param_err
            $error("dcc_packet_scheduler: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_PICK,
        ST_SCAN
    } state_t;

    state_t            state_q, state_d;
    logic [9:0]        idx_prev_q, idx_prev_d;
    logic              pend_q, pend_d;
    logic [31:0]       cmd_word_q, cmd_word_d;
    logic [1:0]        cur_src_q, cur_src_d;
    logic [SW-1:0]     cur_slot_q, cur_slot_d;
    logic              q_full_q, q_full_d;
    logic              q_overflow_q, q_overflow_d;
    logic [29:0]       q_mem_q [QDEPTH];
    logic [29:0]       q_mem_d [QDEPTH];
    logic [QW-1:0]     q_wp_q, q_wp_d;
    logic [QW-1:0]     q_rp_q, q_rp_d;
    logic [CW-1:0]     q_cnt_q, q_cnt_d;
    logic [RW-1:0]     rep_q, rep_d;
    logic [SLOTS-1:0]  slot_en_q, slot_en_d;
    logic [29:0]       slot_data_q [SLOTS];
    logic [29:0]       slot_data_d [SLOTS];
    logic [SW-1:0]     rr_q, rr_d;
    logic [SW-1:0]     scan_ptr_q, scan_ptr_d;
    logic [SW-1:0]     scan_cnt_q, scan_cnt_d;

`ifdef DCC_SCHED_FAIRNESS_EN
    localparam int unsigned FW = $clog2(FAIR_LIMIT + 1);
    logic [FW-1:0]     fair_q, fair_d;
`endif

    logic done;
    logic q_empty;
    logic q_full_now;
    logic q_pop;
    logic q_push;
    logic serve_q;

    assign done       = (eng_index != idx_prev_q);
    assign q_empty    = (q_cnt_q == '0);
    assign q_full_now = (q_cnt_q == CW'(QDEPTH));

    assign cmd_word   = cmd_word_q;
    assign cur_src    = cur_src_q;
    assign cur_slot   = cur_slot_q;
    assign q_full     = q_full_q;
    assign q_overflow = q_overflow_q;

    // Next-state, arbitration, queue and slot-table updates
    always_comb begin
        state_d      = state_q;
        idx_prev_d   = eng_index;
        pend_d       = pend_q;
        cmd_word_d   = cmd_word_q;
        cur_src_d    = cur_src_q;
        cur_slot_d   = cur_slot_q;
        q_mem_d      = q_mem_q;
        q_wp_d       = q_wp_q;
        q_rp_d       = q_rp_q;
        q_cnt_d      = q_cnt_q;
        rep_d        = rep_q;
        slot_en_d    = slot_en_q;
        slot_data_d  = slot_data_q;
        rr_d         = rr_q;
        scan_ptr_d   = scan_ptr_q;
        scan_cnt_d   = scan_cnt_q;
        q_pop        = 1'b0;
        q_push       = 1'b0;
        q_overflow_d = 1'b0;
        serve_q      = 1'b0;
`ifdef DCC_SCHED_FAIRNESS_EN
        fair_d       = fair_q;
`endif

        if (slot_wr) begin
            slot_en_d[slot_sel]   = slot_en;
            slot_data_d[slot_sel] = slot_data;
        end

        unique case (state_q)
            ST_WAIT: begin
                if (done || pend_q) begin
                    state_d = ST_PICK;
                    pend_d  = 1'b0;
                end
            end
            ST_PICK: begin
                if (done) pend_d = 1'b1;
`ifdef DCC_SCHED_FAIRNESS_EN
                serve_q = !q_empty && !((fair_q == FW'(FAIR_LIMIT)) && (|slot_en_q));
`else
                serve_q = !q_empty;
`endif
                if (serve_q) begin
                    cmd_word_d = {2'b00, q_mem_q[q_rp_q]};
                    cur_src_d  = SRC_QUEUE;
                    if (rep_q + RW'(1) == RW'(REPEAT)) begin
                        q_pop = 1'b1;
                        rep_d = '0;
                    end else begin
                        rep_d = rep_q + RW'(1);
                    end
`ifdef DCC_SCHED_FAIRNESS_EN
                    if (fair_q != FW'(FAIR_LIMIT)) fair_d = fair_q + FW'(1);
`endif
                    state_d = ST_WAIT;
                end else begin
                    scan_ptr_d = rr_q + SW'(1);
                    scan_cnt_d = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (done) pend_d = 1'b1;
                if (slot_en_q[scan_ptr_q]) begin
                    cmd_word_d = {2'b00, slot_data_q[scan_ptr_q]};
                    cur_src_d  = SRC_REFR;
                    cur_slot_d = scan_ptr_q;
                    rr_d       = scan_ptr_q;
                    state_d    = ST_WAIT;
`ifdef DCC_SCHED_FAIRNESS_EN
                    fair_d     = '0;
`endif
                end else if (scan_cnt_q == SW'(SLOTS - 1)) begin
                    cmd_word_d = IDLE_WORD;
                    cur_src_d  = SRC_IDLE;
                    state_d    = ST_WAIT;
`ifdef DCC_SCHED_FAIRNESS_EN
                    fair_d     = '0;
`endif
                end else begin
                    scan_ptr_d = scan_ptr_q + SW'(1);
                    scan_cnt_d = scan_cnt_q + SW'(1);
                end
            end
            default: state_d = ST_WAIT;
        endcase

        // A pop in the same cycle frees the entry a full-queue push needs
        q_push       = q_wr && (!q_full_now || q_pop);
        q_overflow_d = q_wr && q_full_now && !q_pop;
        if (q_push) begin
            q_mem_d[q_wp_q] = q_data;
            q_wp_d          = q_wp_q + QW'(1);
        end
        if (q_pop) q_rp_d = q_rp_q + QW'(1);
        q_cnt_d  = q_cnt_q + CW'(q_push) - CW'(q_pop);
        q_full_d = (q_cnt_d == CW'(QDEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WAIT;
            idx_prev_q   <= '0;
            pend_q       <= 1'b0;
            cmd_word_q   <= IDLE_WORD;
            cur_src_q    <= SRC_IDLE;
            cur_slot_q   <= '0;
            q_full_q     <= 1'b0;
            q_overflow_q <= 1'b0;
            q_mem_q      <= '{default: '0};
            q_wp_q       <= '0;
            q_rp_q       <= '0;
            q_cnt_q      <= '0;
            rep_q        <= '0;
            slot_en_q    <= '0;
            slot_data_q  <= '{default: '0};
            rr_q         <= SW'(SLOTS - 1);
            scan_ptr_q   <= '0;
            scan_cnt_q   <= '0;
`ifdef DCC_SCHED_FAIRNESS_EN
            fair_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_prev_q   <= idx_prev_d;
            pend_q       <= pend_d;
            cmd_word_q   <= cmd_word_d;
            cur_src_q    <= cur_src_d;
            cur_slot_q   <= cur_slot_d;
            q_full_q     <= q_full_d;
            q_overflow_q <= q_overflow_d;
            q_mem_q      <= q_mem_d;
            q_wp_q       <= q_wp_d;
            q_rp_q       <= q_rp_d;
            q_cnt_q      <= q_cnt_d;
            rep_q        <= rep_d;
            slot_en_q    <= slot_en_d;
            slot_data_q  <= slot_data_d;
            rr_q         <= rr_d;
            scan_ptr_q   <= scan_ptr_d;
            scan_cnt_q   <= scan_cnt_d;
`ifdef DCC_SCHED_FAIRNESS_EN
            fair_q       <= fair_d;
`endif
        end
    end

endmodule

// File: tb/tb_dcc_packet_scheduler.sv
// Directed bench for dcc_packet_scheduler (default parameters, fairness macro undefined).
module tb_dcc_packet_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  eng_index;
    logic [31:0] cmd_word;
    logic        slot_wr;
    logic [2:0]  slot_sel;
    logic        slot_en;
    logic [29:0] slot_data;
    logic        q_wr;
    logic [29:0] q_data;
    logic        q_full;
    logic        q_overflow;
    logic [1:0]  cur_src;
    logic [2:0]  cur_slot;

    int n_pass = 0;
    int n_total = 0;

    dcc_packet_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .eng_index  (eng_index),
        .cmd_word   (cmd_word),
        .slot_wr    (slot_wr),
        .slot_sel   (slot_sel),
        .slot_en    (slot_en),
        .slot_data  (slot_data),
        .q_wr       (q_wr),
        .q_data     (q_data),
        .q_full     (q_full),
        .q_overflow (q_overflow),
        .cur_src    (cur_src),
        .cur_slot   (cur_slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          push;
        logic [29:0] qd;
        logic [31:0] word;
        logic [1:0]  src;
        logic [2:0]  slot;
    } vec_t;

    vec_t vecs[11];
    logic [31:0] qseq[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Longest service path is 2 + SLOTS cycles; leave margin
    task automatic advance();
        eng_index = eng_index + 10'd1;
        repeat (14) tick();
    endtask

    task automatic wr_slot(input logic [2:0] sel, input logic en, input logic [29:0] d);
        slot_sel  = sel;
        slot_en   = en;
        slot_data = d;
        slot_wr   = 1'b1;
        tick();
        slot_wr   = 1'b0;
    endtask

    task automatic push(input logic [29:0] d);
        q_data = d;
        q_wr   = 1'b1;
        tick();
        q_wr   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; eng_index = '0; slot_wr = 1'b0; slot_sel = '0; slot_en = 1'b0;
        slot_data = '0; q_wr = 1'b0; q_data = '0;

        vecs[0]  = '{1'b0, 30'h0,        32'h0D003F03, 2'b10, 3'd2};
        vecs[1]  = '{1'b0, 30'h0,        32'h0D001122, 2'b10, 3'd5};
        vecs[2]  = '{1'b0, 30'h0,        32'h0D003F03, 2'b10, 3'd2};
        vecs[3]  = '{1'b0, 30'h0,        32'h0D001122, 2'b10, 3'd5};
        vecs[4]  = '{1'b0, 30'h0,        32'h0D003F03, 2'b10, 3'd2};
        vecs[5]  = '{1'b0, 30'h0,        32'h0D001122, 2'b10, 3'd5};
        vecs[6]  = '{1'b1, 30'h0E002211, 32'h0E002211, 2'b01, 3'd5};
        vecs[7]  = '{1'b0, 30'h0,        32'h0E002211, 2'b01, 3'd5};
        vecs[8]  = '{1'b0, 30'h0,        32'h0E002211, 2'b01, 3'd5};
        vecs[9]  = '{1'b0, 30'h0,        32'h0D003F03, 2'b10, 3'd2};
        vecs[10] = '{1'b0, 30'h0,        32'h0D001122, 2'b10, 3'd5};

        qseq[0] = 32'h0E000A01; qseq[1] = 32'h0E000B02; qseq[2] = 32'h0E000C03;
        qseq[3] = 32'h0E000D04; qseq[4] = 32'h0E000E05;

        repeat (3) tick();
        reset = 1'b0;
        chk("rst_cmd_word", cmd_word, 32'h0D0000FF);
        chk("rst_cur_src", 32'(cur_src), 32'h0);
        chk("rst_cur_slot", 32'(cur_slot), 32'h0);
        chk("rst_q_full", 32'(q_full), 32'h0);
        chk("rst_q_overflow", 32'(q_overflow), 32'h0);

        // No work at all: idle packet after each consumption
        for (int i = 0; i < 2; i++) begin
            advance();
            chk("idle_word", cmd_word, 32'h0D0000FF);
            chk("idle_src", 32'(cur_src), 32'h0);
        end

        wr_slot(3'd2, 1'b1, 30'h0D003F03);
        wr_slot(3'd5, 1'b1, 30'h0D001122);

        // Rotation, then queue priority with REPEAT=3, then rotation resumes
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].push) push(vecs[i].qd);
            advance();
            chk($sformatf("vec%0d_word", i), cmd_word, vecs[i].word);
            chk($sformatf("vec%0d_src", i), 32'(cur_src), 32'(vecs[i].src));
            chk($sformatf("vec%0d_slot", i), 32'(cur_slot), 32'(vecs[i].slot));
        end

        // Fill queue, then one dropped push
        for (int i = 0; i < 4; i++) begin
            push(qseq[i][29:0]);
            chk($sformatf("fill%0d_q_full", i), 32'(q_full), (i == 3) ? 32'h1 : 32'h0);
        end
        push(30'h0E00FFFF);
        chk("ovf_pulse", 32'(q_overflow), 32'h1);
        chk("ovf_full", 32'(q_full), 32'h1);
        tick();
        chk("ovf_clear", 32'(q_overflow), 32'h0);

        advance();
        chk("qa1_word", cmd_word, qseq[0]);
        advance();
        chk("qa2_word", cmd_word, qseq[0]);
        // Third send pops head; push lands in the same cycle while full
        eng_index = eng_index + 10'd1;
        tick();
        q_data = qseq[4][29:0];
        q_wr   = 1'b1;
        tick();
        q_wr   = 1'b0;
        chk("pushpop_full", 32'(q_full), 32'h1);
        chk("pushpop_no_ovf", 32'(q_overflow), 32'h0);
        repeat (12) tick();
        chk("qa3_word", cmd_word, qseq[0]);

        for (int p = 1; p < 5; p++) begin
            for (int r = 0; r < 3; r++) begin
                advance();
                chk($sformatf("q%0d_r%0d_word", p, r), cmd_word, qseq[p]);
                chk($sformatf("q%0d_r%0d_src", p, r), 32'(cur_src), 32'h1);
            end
        end
        chk("drained_q_full", 32'(q_full), 32'h0);

        advance();
        chk("resume_word", cmd_word, 32'h0D003F03);
        chk("resume_slot", 32'(cur_slot), 32'h2);

        // Rewriting the current slot leaves cmd_word as copied
        wr_slot(3'd2, 1'b1, 30'h0D004403);
        repeat (3) tick();
        chk("rewrite_hold", cmd_word, 32'h0D003F03);
        advance();
        chk("rewrite_next_slot", 32'(cur_slot), 32'h5);
        chk("rewrite_next_word", cmd_word, 32'h0D001122);
        advance();
        chk("rewrite_new_slot", 32'(cur_slot), 32'h2);
        chk("rewrite_new_word", cmd_word, 32'h0D004403);

        // Disabled slots drop out of rotation
        wr_slot(3'd2, 1'b0, 30'h0);
        wr_slot(3'd5, 1'b0, 30'h0);
        advance();
        chk("disabled_word", cmd_word, 32'h0D0000FF);
        chk("disabled_src", 32'(cur_src), 32'h0);

        // Queue packet with all flags 00 is sent as given
        push(30'h00123456);
        for (int r = 0; r < 3; r++) begin
            advance();
            chk($sformatf("noflag%0d_word", r), cmd_word, 32'h00123456);
        end
        advance();
        chk("after_noflag_idle", cmd_word, 32'h0D0000FF);

        // Reset mid-operation clears queue and slot table
        wr_slot(3'd3, 1'b1, 30'h0D0055AA);
        push(30'h0E007777);
        push(30'h0E008888);
        advance();
        chk("pre_rst_word", cmd_word, 32'h0E007777);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        chk("mid_rst_word", cmd_word, 32'h0D0000FF);
        chk("mid_rst_src", 32'(cur_src), 32'h0);
        chk("mid_rst_q_full", 32'(q_full), 32'h0);
        advance();
        chk("post_rst_word", cmd_word, 32'h0D0000FF);
        chk("post_rst_src", 32'(cur_src), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
